weight_loader_param: RTL and testbench
======================================

WEIGHT_LOADER_PARAM -- requirements
Module: weight_loader_param

Interface
REQ-001 SHALL have parameter IN_SIZE, default 1152: input neurons of the layer.
REQ-002 SHALL have parameter OUT_SIZE, default 8: output neurons of the layer.
REQ-003 SHALL have parameter W, default 8: bits per weight.
REQ-004 SHALL have parameter LANES, default 1: weights per BRAM word.
- IN_SIZE*OUT_SIZE SHALL be a multiple of LANES.
REQ-005 SHALL have parameter RD_LAT, default 2: BRAM read latency in cycles.
- Legal range 1..4.
REQ-006 SHALL have parameter ADDR_WIDTH, default 18: BRAM address bits.
- Derived: TOTAL = IN_SIZE*OUT_SIZE.
- Derived: NREAD = TOTAL/LANES.
REQ-007 Port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-008 Port rst, input, 1 bit: reset; one clock, reset is synchronous and active-high.
REQ-009 Port start, input, 1 bit: load request; sampled only in IDLE or DONE.
REQ-010 Port base_addr, input, ADDR_WIDTH bits: first BRAM address; latched when start is accepted.
REQ-011 Port bram_en, output, 1 bit: BRAM read enable.
REQ-012 Port bram_addr, output, ADDR_WIDTH bits: BRAM read address.
REQ-013 Port bram_dout, input, LANES*W bits: BRAM read data.
- Valid RD_LAT cycles after the address is presented.
REQ-014 Port data_out, output, TOTAL*W bits: flat weight vector.
- Weight j occupies bits [j*W +: W].
REQ-015 Port busy, output, 1 bit: high while a load is in progress.
REQ-016 Port done, output, 1 bit: level, high once all TOTAL weights are captured.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE/DONE with start=1 SHALL go to ISSUE.
- Latch base_addr.
- Clear done.
- Set busy.
- Drive bram_en=1 and bram_addr=base_addr on the next cycle.
REQ-019 ISSUE SHALL present one address per cycle: base_addr+k, for k=0..NREAD-1.
- After the cycle presenting k=NREAD-1: bram_en=0, go to DRAIN.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_WIDTH.
- base_addr+k wraps silently past all-ones to 0.
REQ-021 SHALL track in-flight reads with an RD_LAT-deep valid pipeline.
- Only reads issued in the current load are captured.
REQ-022 Return of read k SHALL be written to data_out[k*LANES*W +: LANES*W].
- Lane i of bram_dout, bits [i*W +: W], SHALL become weight k*LANES+i.
REQ-023 DRAIN SHALL go to DONE on the edge that captures read NREAD-1.
- On that same edge: busy=0, done=1.
REQ-024 Timing: start accepted at edge E0; first address presented after E0; read k captured at edge E(k+RD_LAT).
- done SHALL be visible after E(NREAD-1+RD_LAT).
REQ-025 start during ISSUE or DRAIN SHALL be ignored.
- Current load is unaffected.
REQ-026 start in DONE SHALL begin a new load per REQ-018.
- data_out keeps old contents until each slot is overwritten.
REQ-027 done SHALL stay high in DONE until start or rst.
- busy and done SHALL never be high together.
REQ-028 bram_en SHALL be 0 in IDLE, DRAIN and DONE.
- bram_addr holds its last value outside ISSUE.

Reset
REQ-029 rst=1 at any edge, including mid-load, SHALL force:
- State IDLE.
- bram_en=0, bram_addr=0.
- busy=0, done=0.
- data_out=0.
- Valid pipeline cleared.
REQ-030 BRAM returns arriving after reset SHALL NOT be captured.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Use params IN_SIZE=4, OUT_SIZE=2, W=8, LANES=2, RD_LAT=2 (NREAD=4), with the BRAM model returning {addr+0x11, addr}.
- Stimulus: start, base_addr=0x10.
- Response: addresses 0x10..0x13 on consecutive cycles.
- Response: done high 5 cycles after the start edge.
- Response: data_out = 0x24_13_23_12_22_11_21_10.
REQ-033 Stimulus: base_addr=0x3FFFE with ADDR_WIDTH=18.
- Response: addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-034 Stimulus: start pulsed during ISSUE and during DRAIN.
- Response: no extra addresses issued; done timing unchanged.
REQ-035 Stimulus: rst asserted one cycle after the second address.
- Response: next cycle bram_en=0, data_out=0, busy=0, done=0.
- Response: later BRAM returns leave data_out=0.
REQ-036 Stimulus: load completes, then start with base_addr=0x20.
- Response: done drops.
- Response: slots are overwritten in order.
- Response: final data_out matches the 0x20-based pattern.
REQ-037 Repeat REQ-032 with RD_LAT=1 and RD_LAT=4, LANES=1.
- Response: done at NREAD-1+RD_LAT cycles after the start edge.
- Response: each weight is in the correct slot.

Source files
------------

// File: rtl/weight_loader_param.sv
// Streams a layer's weights out of a BRAM into a flat register vector.
// Reads are issued back to back; returns are matched to reads by an RD_LAT-deep valid pipeline.
module weight_loader_param #(
    parameter int IN_SIZE    = 1152,
    parameter int OUT_SIZE   = 8,
    parameter int W          = 8,
    parameter int LANES      = 1,
    parameter int RD_LAT     = 2,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    output logic                              bram_en,
    output logic [ADDR_WIDTH-1:0]             bram_addr,
    input  logic [LANES*W-1:0]                bram_dout,
    output logic [IN_SIZE*OUT_SIZE*W-1:0]     data_out,
    output logic                              busy,
    output logic                              done
);

    localparam int TOTAL = IN_SIZE * OUT_SIZE;
    localparam int NREAD = TOTAL / LANES;
    localparam int CW    = $clog2(NREAD) + 1;
    localparam logic [CW-1:0] LAST = CW'(NREAD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_en;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [CW-1:0]           r_k;
    logic [CW-1:0]           r_cap;
    logic                    r_busy;
    logic                    r_done;
    logic [RD_LAT-1:0]       r_vld;
    logic [TOTAL*W-1:0]      r_data;

    state_t                  w_state;
    logic                    w_en;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [CW-1:0]           w_k;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_cap;
    logic                    w_cap_last;

    assign w_cap      = r_vld[RD_LAT-1];
    assign w_cap_last = w_cap && (r_cap == LAST);

    // Next-state and next-output decode for the load sequencer.
    always_comb begin
        w_state  = r_state;
        w_en     = 1'b0;
        w_addr   = r_addr;
        w_k      = r_k;
        w_busy   = r_busy;
        w_done   = r_done;
        w_issue  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state  = S_ISSUE;
                    w_en     = 1'b1;
                    w_addr   = base_addr;
                    w_k      = {CW{1'b0}};
                    w_busy   = 1'b1;
                    w_done   = 1'b0;
                    w_issue  = 1'b1;
                    w_accept = 1'b1;
                end else begin
                    w_state = r_state;
                end
            end
            S_ISSUE: begin
                if (r_k == LAST) begin
                    // With RD_LAT=1 the final return lands on the same edge that ends issuing.
                    if (w_cap_last) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_DRAIN;
                    end
                end else begin
                    w_en    = 1'b1;
                    w_addr  = r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    w_k     = r_k + {{(CW-1){1'b0}}, 1'b1};
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_cap_last) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_DRAIN;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_done  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered BRAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_k     <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_en    <= w_en;
            r_addr  <= w_addr;
            r_k     <= w_k;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // In-flight tracking and capture of returned words into their slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= {RD_LAT{1'b0}};
            r_cap  <= {CW{1'b0}};
            r_data <= {(TOTAL*W){1'b0}};
        end else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_accept) begin
                r_cap <= {CW{1'b0}};
            end else if (w_cap) begin
                r_cap <= r_cap + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_cap) begin
                r_data[int'(r_cap) * LANES * W +: LANES * W] <= bram_dout;
            end
        end
    end

    assign bram_en   = r_en;
    assign bram_addr = r_addr;
    assign data_out  = r_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_weight_loader_param.sv
// Three loaders (LANES=2/RD_LAT=2, LANES=1/RD_LAT=1, LANES=1/RD_LAT=4) against a
// per-cycle reference built from the load timeline and an image of the expected weights.
module tb_weight_loader_param;

    logic        clk;
    logic        rst;
    logic [17:0] base_addr;
    logic        start_a [3];
    logic        en_a    [3];
    logic [17:0] addr_a  [3];
    logic [63:0] data_a  [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [15:0] dout_a  [3];
    logic [17:0] hist    [3][4];
    logic [63:0] exp_data [3];

    int n_checks;
    int n_errors;

    weight_loader_param #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .LANES(2), .RD_LAT(2), .ADDR_WIDTH(18)) u_d0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .base_addr(base_addr),
        .bram_en(en_a[0]), .bram_addr(addr_a[0]), .bram_dout(dout_a[0]),
        .data_out(data_a[0]), .busy(busy_a[0]), .done(done_a[0]));

    weight_loader_param #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .LANES(1), .RD_LAT(1), .ADDR_WIDTH(18)) u_d1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .base_addr(base_addr),
        .bram_en(en_a[1]), .bram_addr(addr_a[1]), .bram_dout(dout_a[1][7:0]),
        .data_out(data_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    weight_loader_param #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .LANES(1), .RD_LAT(4), .ADDR_WIDTH(18)) u_d2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .base_addr(base_addr),
        .bram_en(en_a[2]), .bram_addr(addr_a[2]), .bram_dout(dout_a[2][7:0]),
        .data_out(data_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bram_word(input logic [17:0] a);
        return {a[7:0] + 8'h11, a[7:0]};
    endfunction

    // BRAM models: data for an address is on the bus RD_LAT edges after it is presented.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 3; i > 0; i--) hist[d][i] <= hist[d][i-1];
            hist[d][0] <= addr_a[d];
        end
    end

    always_comb begin
        dout_a[0] = bram_word(hist[0][0]);
        dout_a[1] = bram_word(addr_a[1]);
        dout_a[2] = bram_word(hist[2][2]);
    end

    function automatic int lanes_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // Full weight vector a load from 'base' must leave behind.
    function automatic logic [63:0] image(input int lanes, input logic [17:0] base);
        logic [63:0] img;
        logic [17:0] a;
        img = 64'd0;
        for (int j = 0; j < 8; j++) begin
            a = base + 18'(j / lanes);
            img[j*8 +: 8] = a[7:0] + 8'(8'h11 * (j % lanes));
        end
        return img;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("%s d%0d flags", tag, d), {61'd0, en_a[d], busy_a[d], done_a[d]}, 64'd0);
        check($sformatf("%s d%0d addr", tag, d), {46'd0, addr_a[d]}, 64'd0);
        check($sformatf("%s d%0d data", tag, d), data_a[d], 64'd0);
    endtask

    // Called at a negedge. p1/p2: cycles at which start is re-pulsed (ignored by DUT);
    // rst_c: cycle at which rst is raised (-1 for none).
    task automatic run_load(input int d, input logic [17:0] base, input int p1, input int p2, input int rst_c);
        int          nr, lat, t, ncyc, lanes;
        logic [63:0] newd, expd;
        logic [17:0] expa;
        logic [2:0]  expf;
        lanes = lanes_of(d);
        lat   = lat_of(d);
        nr    = 8 / lanes;
        t     = nr - 1 + lat;
        newd  = image(lanes, base);
        ncyc  = (rst_c >= 0) ? rst_c + lat + 4 : t + 3;
        base_addr  = base;
        start_a[d] = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rst_c >= 0 && c > rst_c) begin
                check_zero(d, $sformatf("rst c%0d", c));
            end else begin
                expf = {(c < nr), (c < t), (c >= t)};
                expa = base + 18'((c < nr) ? c : nr - 1);
                for (int j = 0; j < 8; j++) begin
                    expd[j*8 +: 8] = ((j / lanes) + lat <= c) ? newd[j*8 +: 8] : exp_data[d][j*8 +: 8];
                end
                check($sformatf("d%0d c%0d flags", d, c), {61'd0, en_a[d], busy_a[d], done_a[d]}, {61'd0, expf});
                check($sformatf("d%0d c%0d addr", d, c), {46'd0, addr_a[d]}, {46'd0, expa});
                check($sformatf("d%0d c%0d data", d, c), data_a[d], expd);
            end
            start_a[d] = (c == p1 || c == p2);
            if (c == p1 || c == p2) base_addr = 18'($urandom);
            rst = (c == rst_c);
        end
        start_a[d] = 1'b0;
        rst = 1'b0;
        if (rst_c >= 0) begin
            for (int i = 0; i < 3; i++) exp_data[i] = 64'd0;
        end else begin
            exp_data[d] = newd;
        end
    endtask

    initial begin
        int d, lat, t, p1, p2;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        base_addr = 18'd0;
        for (int i = 0; i < 3; i++) begin
            start_a[i]  = 1'b0;
            exp_data[i] = 64'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) check_zero(i, "reset");

        run_load(0, 18'h00010, -1, -1, -1);
        check("d0 image 0x10", data_a[0], 64'h2413_2312_2211_2110);
        run_load(0, 18'h00020, -1, -1, -1);
        run_load(0, 18'h3FFFE, 1, 4, -1);
        run_load(0, 18'h00010, -1, -1, 2);

        rst        = 1'b1;
        start_a[0] = 1'b1;
        base_addr  = 18'h00055;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        start_a[0] = 1'b0;
        check_zero(0, "rst_over_start");
        @(posedge clk);
        @(negedge clk);
        check_zero(0, "rst_over_start idle");

        run_load(1, 18'h00010, -1, -1, -1);
        run_load(2, 18'h00010, 0, 6, -1);
        run_load(2, 18'h3FFFF, -1, -1, -1);

        for (int n = 0; n < 8; n++) begin
            d   = int'($urandom_range(0, 2));
            lat = lat_of(d);
            t   = 8 / lanes_of(d) - 1 + lat;
            p1  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, t - 1));
            p2  = int'($urandom_range(0, t - 1));
            run_load(d, 18'($urandom), p1, p2, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
